pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the number of pipeline segments; WIDTH mod STAGES SHALL be 0, and SEG = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  the operand set on a, b, cin and sub is valid.
REQ-006 in_ready  output  1  the block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for add; borrow-in for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  sum, cout and overflow hold a valid result.
REQ-012 out_ready  input  1  the downstream consumer takes the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of bit WIDTH-1; for subtract this is the inverted borrow.
REQ-015 overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-016 A transfer SHALL occur on an input edge when in_valid and in_ready are both 1, and on an output edge when out_valid and out_ready are both 1.
REQ-017 Operand preparation: B_eff = sub ? ~b : b; c0 = cin XOR sub; the result SHALL equal (a + B_eff + c0) mod 2^WIDTH, with cout equal to carry out of that sum.
REQ-018 Consequently, subtract with cin=0 SHALL give a - b, and subtract with cin=1 SHALL give a - b - 1.
REQ-019 Stage k (k = 0..STAGES-1) SHALL add bits [k*SEG +: SEG] of a and B_eff plus the registered carry out of stage k-1 (c0 for stage 0), and register the SEG-bit partial sum and carry.
REQ-020 Higher operand segments SHALL travel through delay registers so that each stage receives bits of the same transaction; lower partial sums SHALL be carried forward with it.
REQ-021 overflow SHALL be computed in the last stage as carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 Each stage SHALL have a valid flag; the last stage's flag and registers SHALL drive out_valid, sum, cout and overflow directly, with no combinational path from a or b to the outputs.
REQ-023 Latency: a transaction accepted at edge N SHALL produce out_valid=1 after edge N+STAGES-1 when there is no stall, so it is visible for the cycle following that edge.
REQ-024 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-025 Global advance: adv = ~out_valid | out_ready; all stage registers and valid flags SHALL update only when adv=1, and in_ready SHALL equal adv.
REQ-026 When adv=1 and in_valid=0, a bubble (valid flag 0) SHALL enter stage 0.
REQ-027 Stall: while out_valid=1 and out_ready=0, sum, cout, overflow and every internal stage SHALL hold stable.
REQ-028 Ordering: results SHALL leave in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-029 Simultaneous output transfer and new input on the same edge SHALL be supported, with full pipeline occupancy maintained.
REQ-030 STAGES=1 SHALL be legal and give latency 1.
REQ-031 STAGES=WIDTH SHALL be legal and give a 1-bit segment per stage.
REQ-032 Data registers SHALL not be required to clear on bubbles; only valid flags qualify data.

Reset
REQ-033 While rst_n=0, all valid flags SHALL be 0 and sum, cout and overflow SHALL be 0, immediately and independently of clk.
REQ-034 in_ready SHALL be 1 during reset.
REQ-035 Asserting reset mid-operation SHALL discard all in-flight transactions; after release, the first output SHALL be the first transaction accepted after release.

Verification
REQ-036 WIDTH=16, STAGES=4, add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0, out_valid 4 cycles after acceptance.
REQ-037 Add 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; add 0x1234 + 0x4321, cin=1 -> sum=0x5556, cout=0, overflow=0.
REQ-038 sub=1, 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0, overflow=0; 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, overflow=1.
REQ-039 Stream 8 back-to-back transactions with out_ready held low after the first result -> in_ready=0 once the pipeline is full and outputs stay stable; release out_ready -> all 8 results arrive in order, one per cycle, none lost or duplicated.
REQ-040 Reset asserted with 3 transactions in flight -> out_valid=0 immediately; after release, the next accepted 0x0001 + 0x0001 yields sum=0x0002 as the first output.
REQ-041 Randomised in_valid/out_ready for STAGES in {1, 2, 4, 16} -> every result matches the (a + B_eff + c0) reference model with correct cout and overflow.

Source files
------------

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Carry-segmented add/subtract pipeline. The WIDTH-bit operation is split
//   into STAGES segments of SEG = WIDTH/STAGES bits. Stage k adds segment k
//   of A and B_eff with the registered carry from stage k-1. The untouched
//   upper operand bits and the finished lower partial sums travel alongside,
//   so each stage works on a single transaction. A single global advance
//   signal moves the whole pipeline, which stalls when the output is held.
//
// Parameters
//   WIDTH   operand / sum width in bits
//   STAGES  number of pipeline segments (WIDTH must be a multiple of STAGES)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set on a/b/cin/sub is valid
//   in_ready   operand set is accepted this cycle (equals global advance)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0 = add, 1 = subtract
//   out_valid  sum/cout/overflow hold a valid result
//   out_ready  downstream takes the result this cycle
//   sum        result
//   cout       carry-out of bit WIDTH-1 (inverted borrow for subtract)
//   overflow   two's-complement signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registered state
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  opa_q  [STAGES];
    logic [WIDTH-1:0]  opa_d  [STAGES];
    logic [WIDTH-1:0]  opb_q  [STAGES];
    logic [WIDTH-1:0]  opb_d  [STAGES];
    logic [WIDTH-1:0]  psum_q [STAGES];
    logic [WIDTH-1:0]  psum_d [STAGES];
    logic              ovf_q, ovf_d;

    // Inputs seen by each stage: stage 0 takes the prepared operands,
    // stage k>0 takes the registers of stage k-1.
    logic [STAGES-1:0] in_v;
    logic [STAGES-1:0] in_c;
    logic [WIDTH-1:0]  in_a [STAGES];
    logic [WIDTH-1:0]  in_b [STAGES];
    logic [WIDTH-1:0]  in_s [STAGES];

    logic              adv;
    logic [SEG:0]      seg_sum;

    always_comb begin
        adv = ~vld_q[LAST] | out_ready;

        in_v    = '0;
        in_c    = '0;
        in_a    = opa_q;
        in_b    = opb_q;
        in_s    = psum_q;
        vld_d   = vld_q;
        cry_d   = cry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        ovf_d   = ovf_q;
        seg_sum = '0;

        in_v[0] = in_valid;
        in_a[0] = a;
        in_b[0] = sub ? ~b : b;
        in_c[0] = cin ^ sub;
        in_s[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            in_v[k] = vld_q[k-1];
            in_a[k] = opa_q[k-1];
            in_b[k] = opb_q[k-1];
            in_c[k] = cry_q[k-1];
            in_s[k] = psum_q[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, in_a[k][k*SEG +: SEG]}
                    + {1'b0, in_b[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, in_c[k]};
            vld_d[k]  = in_v[k];
            opa_d[k]  = in_a[k];
            opb_d[k]  = in_b[k];
            psum_d[k] = in_s[k];
            psum_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            cry_d[k]  = seg_sum[SEG];
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            if (k == LAST) begin
                ovf_d = in_a[k][WIDTH-1] ^ in_b[k][WIDTH-1]
                      ^ seg_sum[SEG-1] ^ seg_sum[SEG];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                psum_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            ovf_q <= ovf_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                opa_q[k]  <= opa_d[k];
                opb_q[k]  <= opb_d[k];
                psum_q[k] <= psum_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign sum       = psum_q[LAST];
    assign cout      = cry_q[LAST];
    assign overflow  = ovf_q;

endmodule
